// File: rtl/sccomp_dump_ctrl.sv
// sccomp_dump_ctrl: halts the core at HALT_PC and streams a 35-word state dump
// (halt PC, halt instruction, retired count, r0-r31) over valid/ready.
module sccomp_dump_ctrl #(
    parameter logic [31:0] HALT_PC = 32'h0000_0048,
    parameter int          CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic        o_cpu_stall,
    output logic [4:0]  o_rf_raddr,
    input  logic [31:0] i_rf_rdata,
    output logic        o_dump_valid,
    input  logic        i_dump_ready,
    output logic [31:0] o_dump_data,
    output logic        o_dump_last,
    output logic        o_dump_done
);
    typedef enum logic [2:0] {RUN, S_PC, S_INSTR, S_CNT, S_REG, DONE} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_idx;
    logic [31:0]      r_hpc, r_hinstr;
    logic             w_halt, w_hs;

    always_comb begin
        w_halt       = (r_state == RUN) && (i_pc == HALT_PC);
        o_dump_valid = (r_state != RUN) && (r_state != DONE);
        w_hs         = o_dump_valid && i_dump_ready;
        o_cpu_stall  = w_halt || (r_state != RUN);
        o_dump_done  = (r_state == DONE);
        o_dump_last  = (r_state == S_REG) && (r_idx == 5'd31);
        o_rf_raddr   = (r_state == S_REG) ? r_idx : 5'd0;
        o_dump_data  = (r_state == S_PC)    ? r_hpc :
                       (r_state == S_INSTR) ? r_hinstr :
                       (r_state == S_CNT)   ? 32'(r_cnt) :
                       (r_state == S_REG && r_idx != 5'd0) ? i_rf_rdata : 32'd0;
        w_next = r_state;
        case (r_state)
            RUN:     w_next = w_halt ? S_PC : RUN;
            S_PC:    w_next = w_hs ? S_INSTR : S_PC;
            S_INSTR: w_next = w_hs ? S_CNT : S_INSTR;
            S_CNT:   w_next = w_hs ? S_REG : S_CNT;
            S_REG:   w_next = (w_hs && o_dump_last) ? DONE : S_REG;
            default: w_next = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= RUN;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_hpc    <= '0;
            r_hinstr <= '0;
        end else begin
            r_state <= w_next;
            if (w_halt) begin
                r_hpc    <= i_pc;
                r_hinstr <= i_instr;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == S_CNT && w_hs)
                r_idx <= '0;
            else if (r_state == S_REG && w_hs)
                r_idx <= r_idx + 5'd1;
        end
    end
endmodule

// File: tb/tb_sccomp_dump_ctrl.sv
// tb_sccomp_dump_ctrl: scoreboard bench for the halt/dump sequencer, with a
// second CNT_W=4 instance for counter wrap.
module tb_sccomp_dump_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1, rst4 = 1'b1;
    logic [31:0] pc = 32'd0, pc4 = 32'd0, instr, instr4;
    logic        stall, stall4, dvalid, dvalid4, dready = 1'b0, dready4 = 1'b1;
    logic [4:0]  raddr, raddr4;
    logic [31:0] rdata, rdata4, ddata, ddata4;
    logic        dlast, dlast4, done, done4;
    logic [31:0] rf [32];

    int tests = 0, fails = 0, accepted = 0, idx4 = 0;
    logic [32:0] q [$];
    logic        hold = 1'b0;
    logic [32:0] held;

    always #5 clk = ~clk;

    assign instr  = 32'h13 + (pc << 8);
    assign instr4 = 32'h13 + (pc4 << 8);
    assign rdata  = rf[raddr];
    assign rdata4 = rf[raddr4];

    sccomp_dump_ctrl dut (
        .clk(clk), .rst(rst), .i_pc(pc), .i_instr(instr), .o_cpu_stall(stall),
        .o_rf_raddr(raddr), .i_rf_rdata(rdata), .o_dump_valid(dvalid),
        .i_dump_ready(dready), .o_dump_data(ddata), .o_dump_last(dlast),
        .o_dump_done(done)
    );

    sccomp_dump_ctrl #(.HALT_PC(32'h48), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .i_pc(pc4), .i_instr(instr4), .o_cpu_stall(stall4),
        .o_rf_raddr(raddr4), .i_rf_rdata(rdata4), .o_dump_valid(dvalid4),
        .i_dump_ready(dready4), .o_dump_data(ddata4), .o_dump_last(dlast4),
        .o_dump_done(done4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main instance: scoreboard pop on handshake, hold check under backpressure.
    always @(negedge clk) begin
        if (dvalid && dready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h expected none", {dlast, ddata});
            end else begin
                chk("word", {31'd0, dlast, ddata}, {31'd0, q.pop_front()});
            end
            accepted++;
        end
        if (hold && dvalid)
            chk("hold_stable", {31'd0, dlast, ddata}, {31'd0, held});
        hold = dvalid && !dready;
        held = {dlast, ddata};
    end

    always @(negedge clk) begin
        if (dvalid4 && dready4) begin
            if (idx4 == 0) chk("cnt4_hpc", ddata4, 32'h48);
            if (idx4 == 2) chk("cnt4_wrap", ddata4, 32'h4);
            idx4++;
        end
    end

    task automatic push_dump;
        q.push_back({1'b0, 32'h0000_0048});
        q.push_back({1'b0, 32'h0000_4813});
        q.push_back({1'b0, 32'h0000_0012});
        for (int k = 0; k < 32; k++)
            q.push_back({k == 31, (k == 0) ? 32'd0 : 32'(k) * 32'h1111_1111});
    endtask

    task automatic start_prog;
        rst = 1'b1;
        pc = 32'd0;
        dready = 1'b1;
        tick;
        rst = 1'b0;
        push_dump;
        for (int k = 0; k <= 18; k++) begin
            pc = 32'(k * 4);
            #1;
            chk("stall_at_pc", {63'd0, stall}, {63'd0, k == 18});
            if (k < 18) tick;
        end
    endtask

    task automatic run(input bit toggle, input int exp_cycles);
        int n = 0;
        start_prog;
        dready = 1'b1;
        while (!done && n < 300) begin
            tick;
            n++;
            dready = toggle ? (n % 2 == 0) : 1'b1;
        end
        chk("done_cycle", 64'(n), 64'(exp_cycles));
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("valid_in_done", {63'd0, dvalid}, 64'd0);
    endtask

    initial begin
        int n;
        rf[0] = 32'hDEAD_BEEF;
        for (int k = 1; k < 32; k++) rf[k] = 32'(k) * 32'h1111_1111;

        // Reset held while pc sits at the halt address.
        rst = 1'b1;
        pc = 32'h48;
        tick;
        tick;
        chk("rst_stall", {63'd0, stall}, 64'd1);
        chk("rst_valid", {63'd0, dvalid}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_data", ddata, 64'd0);
        chk("rst_last", {63'd0, dlast}, 64'd0);
        chk("rst_raddr", {59'd0, raddr}, 64'd0);

        run(1'b0, 36);
        run(1'b1, 71);

        // Reset mid-dump at r10, then restart.
        start_prog;
        n = 0;
        while (!(dvalid && raddr == 5'd10) && n < 100) begin
            tick;
            n++;
        end
        chk("reach_idx10", 64'(accepted % 35), 64'd13);
        rst = 1'b1;
        dready = 1'b0;
        tick;
        chk("midrst_valid", {63'd0, dvalid}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd1);
        q.delete();
        run(1'b0, 36);

        // DONE is sticky regardless of pc and ready.
        for (int k = 0; k < 100; k++) begin
            pc = $urandom;
            dready = k[0];
            tick;
            if (dvalid !== 1'b0 || stall !== 1'b1 || done !== 1'b1)
                chk("done_sticky", {61'd0, dvalid, stall, done}, 64'b011);
        end
        chk("done_sticky_end", {61'd0, dvalid, stall, done}, 64'b011);

        // CNT_W=4: 20 non-halt cycles wrap the count to 4.
        rst4 = 1'b1;
        pc4 = 32'h100;
        tick;
        rst4 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick;
            pc4 = (k == 19) ? 32'h48 : 32'h104 + 32'(k * 4);
        end
        n = 0;
        while (!done4 && n < 100) begin
            tick;
            n++;
        end
        chk("cnt4_done_cycle", 64'(n), 64'd36);
        chk("cnt4_words", 64'(idx4), 64'd35);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
